// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the registered sequential ALU (alu_seq_mc):
//   - 4-bit opcode encodings (codes 13-15 are illegal)
//   - FSM state encoding (IDLE / BUSY / DONE)
//   - flag bundle held in the output register alongside the result
// -----------------------------------------------------------------------------
package alu_seq_pkg;

   localparam logic [3:0] OP_SGE   = 4'd0;
   localparam logic [3:0] OP_PASSB = 4'd1;
   localparam logic [3:0] OP_MUL   = 4'd2;
   localparam logic [3:0] OP_SGT   = 4'd3;
   localparam logic [3:0] OP_XNOR  = 4'd4;
   localparam logic [3:0] OP_SLL   = 4'd5;
   localparam logic [3:0] OP_SLTU  = 4'd6;
   localparam logic [3:0] OP_OR    = 4'd7;
   localparam logic [3:0] OP_ADD   = 4'd8;
   localparam logic [3:0] OP_SUB   = 4'd9;
   localparam logic [3:0] OP_AND   = 4'd10;
   localparam logic [3:0] OP_SRL   = 4'd11;
   localparam logic [3:0] OP_SRA   = 4'd12;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef struct packed {
      logic carry;
      logic zero;
      logic ovf;
      logic sign;
      logic err;
   } flags_t;

endpackage

// File: rtl/alu_seq_mc_mul.sv
// -----------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned shift-add multiplier, one partial-product step per cycle.
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   start_i  latch operands and begin (one-cycle pulse)
//   a_i/b_i  operands, sampled only while start_i is high
//   done_o   one-cycle pulse, high in the cycle after the final step
//   prod_o   full 2*WIDTH product, valid while done_o is high
// The multiplier runs WIDTH steps; done_o rises WIDTH edges after start.
// -----------------------------------------------------------------------------
module alu_mul_iter #(
   parameter int WIDTH = 16
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   a_i,
   input  logic [WIDTH-1:0]   b_i,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o
);

   localparam int CW = $clog2(WIDTH);

   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      if (start_i) begin
         acc_d    = '0;
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         cnt_d    = '0;
         busy_d   = 1'b1;
      end else if (busy_q) begin
         // Multiplicand walks left while the multiplier walks right, so the
         // bit under test is always mplier_q[0].
         if (mplier_q[0]) acc_d = acc_q + mcand_q;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + 1'b1;
         if (cnt_q == CW'(WIDTH - 1)) begin
            busy_d = 1'b0;
            done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign done_o = done_q;
   assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq_mc.sv
// -----------------------------------------------------------------------------
// alu_seq_mc
// Registered ALU with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid / in_ready   operation handshake; opcode/input1/input2/shiftValue
//                         are sampled only on the accept edge
//   out_valid / out_ready result handshake; result and flags held while
//                         out_valid=1 and out_ready=0
//   result, carryFlag, zeroFlag, overFlowFlag, signFlag, op_err
//                         registered result bundle
//   dbg_state_o           current FSM state (IDLE/BUSY/DONE encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, ready is combinational from state
// and out_ready only.
// -----------------------------------------------------------------------------
module alu_seq_mc
   import alu_seq_pkg::*;
#(
   parameter  int WIDTH    = 16,
   parameter  int MUL_ITER = 1,
   localparam int SHW      = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic [SHW-1:0]   shiftValue,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carryFlag,
   output logic             zeroFlag,
   output logic             overFlowFlag,
   output logic             signFlag,
   output logic             op_err,
   output logic [1:0]       dbg_state_o
);

   localparam bit ITER = (MUL_ITER != 0);

   logic [1:0]         state_q, state_d;
   logic [WIDTH-1:0]   result_q, result_d;
   flags_t             flags_q, flags_d;
   logic               accept, mul_start, mul_done;
   logic [2*WIDTH-1:0] iter_prod, prod_1c;
   logic [WIDTH-1:0]   alu_res, mul_res;
   flags_t             alu_flg, mul_flg;
   logic [WIDTH:0]     sll_w, srl_w, add_w, sub_w;
   logic signed [WIDTH:0] sra_w;
   logic               sh_big;

   // rst_n is folded in so in_ready is low for the whole reset assertion.
   assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
   assign accept   = in_valid & in_ready;

   // Constant-folds away when the iterative multiplier is used.
   assign prod_1c = ITER ? '0 : ({{WIDTH{1'b0}}, input1} * {{WIDTH{1'b0}}, input2});

   always_comb begin
      alu_res = '0;
      alu_flg = '0;
      // Shifts are widened by one bit so the last bit shifted out lands in
      // the extra position; a zero shift leaves that position 0.
      sll_w  = {1'b0, input1} << shiftValue;
      srl_w  = {input1, 1'b0} >> shiftValue;
      sra_w  = $signed({input1, 1'b0}) >>> shiftValue;
      add_w  = {1'b0, input1} + {1'b0, input2};
      sub_w  = {1'b0, input1} - {1'b0, input2};   // top bit is the borrow
      sh_big = (int'(shiftValue) >= WIDTH);       // only reachable for non-power-of-2 WIDTH
      case (opcode)
         OP_SGE:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) >= $signed(input2))};
         OP_PASSB: alu_res = input2;
         OP_MUL: begin
            alu_res       = prod_1c[WIDTH-1:0];
            alu_flg.carry = |prod_1c[2*WIDTH-1:WIDTH];
         end
         OP_SGT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(input1) > $signed(input2))};
         OP_XNOR:  alu_res = ~(input1 ^ input2);
         OP_SLL: begin
            alu_res       = sh_big ? '0 : sll_w[WIDTH-1:0];
            alu_flg.carry = sh_big ? 1'b0 : sll_w[WIDTH];
         end
         OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (input1 < input2)};
         OP_OR:    alu_res = input1 | input2;
         OP_ADD: begin
            alu_res       = add_w[WIDTH-1:0];
            alu_flg.carry = add_w[WIDTH];
            alu_flg.ovf   = (input1[WIDTH-1] == input2[WIDTH-1]) &&
                            (add_w[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res       = sub_w[WIDTH-1:0];
            alu_flg.carry = sub_w[WIDTH];
            alu_flg.ovf   = (input1[WIDTH-1] != input2[WIDTH-1]) &&
                            (sub_w[WIDTH-1] != input1[WIDTH-1]);
         end
         OP_AND:   alu_res = input1 & input2;
         OP_SRL: begin
            alu_res       = sh_big ? '0 : srl_w[WIDTH:1];
            alu_flg.carry = sh_big ? 1'b0 : srl_w[0];
         end
         OP_SRA: begin
            alu_res       = sh_big ? {WIDTH{input1[WIDTH-1]}} : sra_w[WIDTH:1];
            alu_flg.carry = sh_big ? 1'b0 : sra_w[0];
         end
         default:  alu_flg.err = 1'b1;
      endcase
      alu_flg.zero = (alu_res == '0);
      alu_flg.sign = alu_res[WIDTH-1];
   end

   // Result bundle for a completed iterative multiply.
   always_comb begin
      mul_res       = iter_prod[WIDTH-1:0];
      mul_flg       = '0;
      mul_flg.carry = |iter_prod[2*WIDTH-1:WIDTH];
      mul_flg.zero  = (mul_res == '0);
      mul_flg.sign  = mul_res[WIDTH-1];
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      flags_d   = flags_q;
      mul_start = 1'b0;
      case (state_q)
         ST_IDLE: ;
         ST_BUSY: begin
            if (mul_done) begin
               state_d  = ST_DONE;
               result_d = mul_res;
               flags_d  = mul_flg;
            end
         end
         ST_DONE: if (out_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
      // accept is only possible in IDLE or in DONE while the result leaves,
      // so it overrides the per-state choice above.
      if (accept) begin
         if ((opcode == OP_MUL) && ITER) begin
            state_d   = ST_BUSY;
            mul_start = 1'b1;
         end else begin
            state_d  = ST_DONE;
            result_d = alu_res;
            flags_d  = alu_flg;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   generate
      if (ITER) begin : g_mul_iter
         alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .start_i (mul_start),
            .a_i     (input1),
            .b_i     (input2),
            .done_o  (mul_done),
            .prod_o  (iter_prod)
         );
      end else begin : g_mul_1c
         assign mul_done  = 1'b0;
         assign iter_prod = '0;
      end
   endgenerate

   assign out_valid    = (state_q == ST_DONE);
   assign result       = result_q;
   assign carryFlag    = flags_q.carry;
   assign zeroFlag     = flags_q.zero;
   assign overFlowFlag = flags_q.ovf;
   assign signFlag     = flags_q.sign;
   assign op_err       = flags_q.err;
   assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_alu_seq_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_mc
// Bench for alu_seq_mc (WIDTH=16, MUL_ITER=1). Expected result bundles are
// packed as {result, carry, zero, ovf, sign, err}.
// -----------------------------------------------------------------------------
module tb_alu_seq_mc;
   import alu_seq_pkg::*;

   localparam int W   = 16;
   localparam int SHW = 4;
   localparam int EW  = W + 5;

   typedef struct {
      string          name;
      logic [3:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [SHW-1:0] sh;
      logic [EW-1:0]  exp;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic           clk;
   logic           rst_n;
   logic           in_valid, in_ready;
   logic [3:0]     opcode;
   logic [W-1:0]   input1, input2;
   logic [SHW-1:0] shiftValue;
   logic           out_valid, out_ready;
   logic [W-1:0]   result;
   logic           carryFlag, zeroFlag, overFlowFlag, signFlag, op_err;
   logic [1:0]     dbg_state;
   logic [EW-1:0]  act_word;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   alu_seq_mc #(.WIDTH(W), .MUL_ITER(1)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .opcode       (opcode),
      .input1       (input1),
      .input2       (input2),
      .shiftValue   (shiftValue),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .result       (result),
      .carryFlag    (carryFlag),
      .zeroFlag     (zeroFlag),
      .overFlowFlag (overFlowFlag),
      .signFlag     (signFlag),
      .op_err       (op_err),
      .dbg_state_o  (dbg_state)
   );

   assign act_word = {result, carryFlag, zeroFlag, overFlowFlag, signFlag, op_err};

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int            n_checks = 0;
   int            n_fail   = 0;
   vec_t          tbl[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [EW-1:0] pk(input logic [W-1:0] r, input logic c, input logic z,
                                        input logic o, input logic s, input logic e);
      return {r, c, z, o, s, e};
   endfunction

   function automatic vec_t mk(input string name, input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [SHW-1:0] sh,
                               input logic [EW-1:0] exp);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.sh = sh; v.exp = exp;
      return v;
   endfunction

   // Reference model used for the randomised phase.
   function automatic logic [EW-1:0] ref_alu(input logic [3:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b, input logic [SHW-1:0] sh);
      logic [W-1:0]        r;
      logic                c, o, e;
      logic [2*W-1:0]      p;
      logic [W:0]          s;
      logic signed [W-1:0] sa;
      int                  n;
      r = '0; c = 1'b0; o = 1'b0; e = 1'b0; n = int'(sh);
      case (op)
         OP_SGE:   r = {{(W-1){1'b0}}, ($signed(a) >= $signed(b))};
         OP_PASSB: r = b;
         OP_MUL: begin
            p = (2*W)'(a) * (2*W)'(b);
            r = p[W-1:0];
            c = (p[2*W-1:W] != '0);
         end
         OP_SGT:   r = {{(W-1){1'b0}}, ($signed(a) > $signed(b))};
         OP_XNOR:  r = ~(a ^ b);
         OP_SLL: begin
            r = a << sh;
            c = (n == 0) ? 1'b0 : a[W-n];
         end
         OP_SLTU:  r = {{(W-1){1'b0}}, (a < b)};
         OP_OR:    r = a | b;
         OP_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[W-1:0];
            c = s[W];
            o = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
         end
         OP_SUB: begin
            r = a - b;
            c = (a < b);
            o = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
         end
         OP_AND:   r = a & b;
         OP_SRL: begin
            r = a >> sh;
            c = (n == 0) ? 1'b0 : a[n-1];
         end
         OP_SRA: begin
            sa = a;
            sa = sa >>> sh;
            r  = sa;
            c  = (n == 0) ? 1'b0 : a[n-1];
         end
         default: e = 1'b1;
      endcase
      return {r, c, (r == '0), o, r[W-1], e};
   endfunction

   // ---------------- driver ----------------
   // Called just after a falling edge. Presents one operation, waits for the
   // result and compares it. edges counts rising edges after the accept edge
   // before out_valid is seen: 0 for single-cycle ops, W+1 for MUL.
   task automatic send(input string name, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [SHW-1:0] sh, input logic [EW-1:0] exp);
      int            edges;
      bit            seen;
      int            exp_edges;
      logic [EW-1:0] e;
      exp_edges  = (op == OP_MUL) ? (W + 1) : 0;
      opcode     = op;
      input1     = a;
      input2     = b;
      shiftValue = sh;
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      exp_q.push_back(exp);
      #1;
      chk({name, " in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      opcode   = 4'($urandom_range(0, 15));
      input1   = W'($urandom);
      input2   = W'($urandom);
      edges    = 0;
      seen     = 1'b0;
      while (!seen && edges <= 40) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1'b1;
         end else begin
            chk({name, " busy in_ready"}, 64'(in_ready), 64'd0);
            input1 = W'($urandom);
            input2 = W'($urandom);
            @(posedge clk);
            edges++;
         end
      end
      e = exp_q.pop_front();
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s timeout: out_valid not seen after %0d edges, expected %0d", name, edges, exp_edges);
      end else begin
         chk({name, " latency"}, 64'(edges), 64'(exp_edges));
         chk(name, 64'(act_word), 64'(e));
      end
   endtask

   task automatic idle_cycle();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
   endtask

   // ---------------- test ----------------
   initial begin : main
      logic [EW-1:0] e;
      bit            saw_valid;
      logic [3:0]    rop;
      logic [W-1:0]  ra, rb;
      logic [SHW-1:0] rsh;

      tbl.push_back(mk("mul_0123x0100", OP_MUL,   16'h0123, 16'h0100, 4'd0, pk(16'h2300, 1, 0, 0, 0, 0)));
      tbl.push_back(mk("add_ovf",       OP_ADD,   16'h7FFF, 16'h0001, 4'd0, pk(16'h8000, 0, 0, 1, 1, 0)));
      tbl.push_back(mk("sub_borrow",    OP_SUB,   16'h0001, 16'h0002, 4'd0, pk(16'hFFFF, 1, 0, 0, 1, 0)));
      tbl.push_back(mk("sge_neg",       OP_SGE,   16'hFFFF, 16'h0001, 4'd0, pk(16'h0000, 0, 1, 0, 0, 0)));
      tbl.push_back(mk("sgt_swap",      OP_SGT,   16'h0001, 16'hFFFF, 4'd0, pk(16'h0001, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("sltu_big",      OP_SLTU,  16'hFFFF, 16'h0001, 4'd0, pk(16'h0000, 0, 1, 0, 0, 0)));
      tbl.push_back(mk("sll_carry",     OP_SLL,   16'h8001, 16'h0000, 4'd1, pk(16'h0002, 1, 0, 0, 0, 0)));
      tbl.push_back(mk("xnor",          OP_XNOR,  16'h00FF, 16'h0F0F, 4'd0, pk(16'hF00F, 0, 0, 0, 1, 0)));
      tbl.push_back(mk("illegal14",     4'd14,    16'h1234, 16'h5678, 4'd3, pk(16'h0000, 0, 1, 0, 0, 1)));
      tbl.push_back(mk("srl_carry",     OP_SRL,   16'h8003, 16'h0000, 4'd2, pk(16'h2000, 1, 0, 0, 0, 0)));
      tbl.push_back(mk("sra_fill",      OP_SRA,   16'h8004, 16'h0000, 4'd3, pk(16'hF000, 1, 0, 0, 1, 0)));
      tbl.push_back(mk("sll_sh0",       OP_SLL,   16'h1234, 16'h0000, 4'd0, pk(16'h1234, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("add_carry",     OP_ADD,   16'hFFFF, 16'h0001, 4'd0, pk(16'h0000, 1, 1, 0, 0, 0)));
      tbl.push_back(mk("sub_ovf",       OP_SUB,   16'h8000, 16'h0001, 4'd0, pk(16'h7FFF, 0, 0, 1, 0, 0)));
      tbl.push_back(mk("and",           OP_AND,   16'hF0F0, 16'h3C3C, 4'd0, pk(16'h3030, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("mul_ffff",      OP_MUL,   16'hFFFF, 16'hFFFF, 4'd0, pk(16'h0001, 1, 0, 0, 0, 0)));
      tbl.push_back(mk("mul_zero",      OP_MUL,   16'h0000, 16'h1234, 4'd0, pk(16'h0000, 0, 1, 0, 0, 0)));
      tbl.push_back(mk("sge_equal",     OP_SGE,   16'h8000, 16'h8000, 4'd0, pk(16'h0001, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("sgt_equal",     OP_SGT,   16'h8000, 16'h8000, 4'd0, pk(16'h0000, 0, 1, 0, 0, 0)));
      tbl.push_back(mk("sltu_small",    OP_SLTU,  16'h0001, 16'hFFFF, 4'd0, pk(16'h0001, 0, 0, 0, 0, 0)));
      tbl.push_back(mk("sra_pos15",     OP_SRA,   16'h4000, 16'h0000, 4'd15, pk(16'h0000, 1, 1, 0, 0, 0)));
      tbl.push_back(mk("sll_15",        OP_SLL,   16'h0001, 16'h0000, 4'd15, pk(16'h8000, 0, 0, 0, 1, 0)));
      tbl.push_back(mk("passb_zero",    OP_PASSB, 16'h1234, 16'h0000, 4'd0, pk(16'h0000, 0, 1, 0, 0, 0)));

      // Reset state
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      out_ready  = 1'b0;
      opcode     = 4'd0;
      input1     = '0;
      input2     = '0;
      shiftValue = '0;
      #2;
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd0);
      chk("reset result/flags", 64'(act_word), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("post-reset in_ready", 64'(in_ready), 64'd1);
      chk("post-reset state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clk);

      // Table vectors, back to back
      for (int i = 0; i < tbl.size(); i++)
         send(tbl[i].name, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].exp);

      // Back-pressure: OR held for 5 cycles, then PASSB accepted as it leaves
      idle_cycle();
      e          = pk(16'h0FF0, 0, 0, 0, 0, 0);
      opcode     = OP_OR;
      input1     = 16'h00F0;
      input2     = 16'h0F00;
      shiftValue = '0;
      out_ready  = 1'b0;
      in_valid   = 1'b1;
      exp_q.push_back(e);
      #1;
      chk("bp accept in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp or result", 64'(act_word), 64'(exp_q.pop_front()));
      for (int k = 0; k < 5; k++) begin
         input1 = W'($urandom);
         input2 = W'($urandom);
         @(negedge clk);
         chk("bp hold result", 64'(act_word), 64'(e));
         chk("bp hold in_ready", 64'(in_ready), 64'd0);
         chk("bp hold out_valid", 64'(out_valid), 64'd1);
      end
      out_ready = 1'b1;
      in_valid  = 1'b1;
      opcode    = OP_PASSB;
      input1    = 16'h1111;
      input2    = 16'hBEEF;
      exp_q.push_back(pk(16'hBEEF, 0, 0, 0, 1, 0));
      #1;
      chk("bp release in_ready", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("bp passb out_valid", 64'(out_valid), 64'd1);
      chk("bp passb result", 64'(act_word), 64'(exp_q.pop_front()));
      @(negedge clk);
      chk("bp drain out_valid", 64'(out_valid), 64'd0);

      // Reset in the middle of a MUL
      opcode    = OP_MUL;
      input1    = 16'h0123;
      input2    = 16'h0100;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (7) @(posedge clk);
      @(negedge clk);
      chk("mid-mul state busy", 64'(dbg_state), 64'(ST_BUSY));
      rst_n = 1'b0;
      #1;
      chk("mid-mul reset out_valid", 64'(out_valid), 64'd0);
      chk("mid-mul reset result/flags", 64'(act_word), 64'd0);
      chk("mid-mul reset in_ready", 64'(in_ready), 64'd0);
      chk("mid-mul reset state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clk);
      rst_n     = 1'b1;
      saw_valid = 1'b0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (out_valid) saw_valid = 1'b1;
      end
      chk("no out_valid after reset", 64'(saw_valid), 64'd0);
      send("xnor_after_reset", OP_XNOR, 16'h00FF, 16'h0F0F, 4'd0, pk(16'hF00F, 0, 0, 0, 1, 0));

      // Randomised ops checked against the reference model
      for (int k = 0; k < 60; k++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = W'($urandom);
         rb  = W'($urandom);
         rsh = SHW'($urandom_range(0, 15));
         if ($urandom_range(0, 3) == 0) idle_cycle();
         send("random", rop, ra, rb, rsh, ref_alu(rop, ra, rb, rsh));
      end

      idle_cycle();
      chk("scoreboard empty", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq_mc.md
Name: alu_seq_mc

Overview:
Parametrised, registered successor to the generated combinational ALUs. Accepts one operation per valid/ready handshake and computes every opcode, including the signed and unsigned compares. Multiply runs as an iterative shift-add over WIDTH cycles, or single-cycle when configured. Result and flags are held in an output register until the consumer accepts them. Sits between the generated ALU harness / operand scheduler and the writeback stage.

Parameters:
WIDTH, 16, operand/result width (>=4)
SHW, $clog2(WIDTH), shiftValue width (derived, not overridable)
MUL_ITER, 1, 1 = iterative multiply (WIDTH cycles), 0 = single-cycle multiply

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation presented
in_ready  out  1  block can accept an operation this cycle
opcode  in  4  operation select
input1  in  WIDTH  operand A
input2  in  WIDTH  operand B
shiftValue  in  SHW  shift amount
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
carryFlag  out  1  registered carry/borrow
zeroFlag  out  1  result == 0
overFlowFlag  out  1  signed overflow
signFlag  out  1  result[WIDTH-1]
op_err  out  1  illegal opcode captured

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, sync-clean deassert): state=IDLE. out_valid, result, all flags, op_err and the internal counter all 0. in_ready forced 0 while rst_n low.
- Opcodes: 0 SGE, 1 PASSB, 2 MUL, 3 SGT, 4 XNOR, 5 SLL, 6 SLTU, 7 OR, 8 ADD, 9 SUB, 10 AND, 11 SRL, 12 SRA. Codes 13-15 are illegal.
- Compares (SGE signed >=, SGT signed >, SLTU unsigned <): result = {WIDTH-1 zeros, cmp_bit}.
- MUL: result = low WIDTH bits of unsigned product.
- carryFlag:
  - ADD: carry-out.
  - SUB: borrow (1 iff input1 < input2 unsigned).
  - SLL/SRL/SRA: last bit shifted out; 0 when shiftValue = 0.
  - MUL: 1 iff the upper WIDTH product bits are nonzero.
  - All other opcodes: 0.
- overFlowFlag: signed overflow for ADD/SUB; 0 for all other opcodes.
- zeroFlag and signFlag: derived from the final result for every opcode.
- Illegal opcode: result 0, zeroFlag 1, all other flags 0, op_err 1. Completes as a single-cycle op. op_err is 0 for legal opcodes.
- State machine: IDLE, BUSY, DONE.
  - IDLE: in_valid & in_ready accept edge. Non-MUL (or MUL with MUL_ITER=0): result/flags registered at that edge, go to DONE; out_valid is high the next cycle (latency 1). MUL with MUL_ITER=1: latch operands, cnt=0, go to BUSY.
  - BUSY: one shift-add step per cycle. After WIDTH steps, register result/flags and go to DONE. out_valid is high WIDTH+1 edges after the accept edge.
  - DONE: out_valid=1; outputs stable while out_ready=0. On out_valid & out_ready, leave DONE. If a new op is accepted on the same edge, run it as from IDLE; otherwise go to IDLE and drop out_valid.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Combinational from state and out_ready. Always 0 in BUSY.
- Operands are sampled only at the accept edge. Input changes during BUSY/DONE are ignored.
- Shifts: shiftValue >= WIDTH (non-power-of-2 WIDTH only): SLL/SRL give 0, SRA gives sign-fill, carry = 0.
- Reset mid-BUSY or mid-DONE: operation discarded, no out_valid pulse afterwards.

Decomposition:
- Package alu_seq_pkg: 4-bit opcode localparams (0-12 above), state encoding (IDLE/BUSY/DONE), flag-bundle struct.
- Sub-module alu_mul_iter:
  - Inputs: start, operand A/B.
  - Outputs: done pulse, 2*WIDTH product.
  - Owns the cycle counter and the partial-product register.
  - Instantiated only when MUL_ITER=1.
- The rest (compare/logic/shift/add datapath and flag generation) is combinational in the top module, feeding the output register.

Test Plan:
1. WIDTH=16, MUL_ITER=1, MUL 0x0123*0x0100 -> result 0x2300, carryFlag 1, zeroFlag 0, out_valid exactly 17 edges after accept; in_ready 0 throughout BUSY.
2. ADD 0x7FFF+0x0001 -> 0x8000, overFlowFlag 1, signFlag 1, carryFlag 0. SUB 0x0001-0x0002 -> 0xFFFF, carryFlag 1, overFlowFlag 0.
3. input1=0xFFFF, input2=0x0001: SGE -> 0x0000, SGT with swapped operands -> 0x0001, SLTU -> 0x0000. SLL 0x8001 by 1 -> 0x0002, carryFlag 1.
4. Back-pressure: complete an OR with out_ready=0 for 5 cycles -> result/flags stable, in_ready 0. Raise out_ready with in_valid=1 (PASSB 0xBEEF) -> next cycle result 0xBEEF, out_valid stays 1.
5. Illegal opcode 14 -> result 0x0000, zeroFlag 1, op_err 1, latency 1.
6. Assert rst_n low at cycle 8 of a MUL -> all outputs 0 immediately. After release, no out_valid until a new accept; a following XNOR 0x00FF,0x0F0F -> 0xF00F.
